// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Operation/result bundle between the execute stage, the memory access unit
// and writeback.
//   slave  : the memory access unit (consumes operations, produces results)
//   master : the upstream/downstream side (presents operations, sees results)
// Operation side : stall_in, valid_in, read, write, no_mem, data, address,
//                  address_mode, rd
// Result side    : rd_out, data_out, we_out, valid_out, fault_out, stall_out
// ---------------------------------------------------------------------------
interface mem_access_unit_if #(
  parameter int WIDTH     = 32,
  parameter int ADR_WIDTH = 24,
  parameter int RS_WIDTH  = 5
);
  logic                 stall_in;
  logic                 valid_in;
  logic                 read;
  logic                 write;
  logic                 no_mem;
  logic [WIDTH-1:0]     data;
  logic [ADR_WIDTH-1:0] address;
  logic [2:0]           address_mode;
  logic [RS_WIDTH-1:0]  rd;

  logic [RS_WIDTH-1:0]  rd_out;
  logic [WIDTH-1:0]     data_out;
  logic                 we_out;
  logic                 valid_out;
  logic                 fault_out;
  logic                 stall_out;

  modport slave (
    input  stall_in, valid_in, read, write, no_mem, data, address,
           address_mode, rd,
    output rd_out, data_out, we_out, valid_out, fault_out, stall_out
  );

  modport master (
    output stall_in, valid_in, read, write, no_mem, data, address,
           address_mode, rd,
    input  rd_out, data_out, we_out, valid_out, fault_out, stall_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Memory stage between execute and writeback. Owns a word-organised,
// little-endian data RAM with byte enables. Each RAM beat takes MEM_LATENCY
// cycles; byte/half/word accesses that straddle a word boundary are split
// into two beats (low bytes first, then the next word, wrapping at the top).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (control and output registers only;
//          RAM contents survive)
//   bus  : mem_access_unit_if.slave -- operation in, writeback result out
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int WIDTH       = 32,
  parameter int ADR_WIDTH   = 24,
  parameter int RS_WIDTH    = 5,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

  localparam int         WA       = ADR_WIDTH - 2;
  localparam int         DEPTH    = 2 ** WA;
  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, HOLD} state_t;

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [ADR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]           mode_q, mode_d;
  logic [WIDTH-1:0]     wdat_q, wdat_d;
  logic [RS_WIDTH-1:0]  rd_q, rd_d;
  logic                 store_q, store_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [RS_WIDTH-1:0]  rd_out_q, rd_out_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 we_out_q, we_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 fault_out_q, fault_out_d;

  logic [WIDTH-1:0]     mem [DEPTH];

  function automatic logic legal_mode(input logic [2:0] m);
    return (m == 3'd0) || (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5);
  endfunction

  function automatic logic [WIDTH-1:0] extend(input logic [WIDTH-1:0] raw,
                                              input logic [2:0]       m);
    case (m)
      3'd0:    return {{(WIDTH-8){raw[7]}}, raw[7:0]};
      3'd1:    return {{(WIDTH-16){raw[15]}}, raw[15:0]};
      3'd4:    return {{(WIDTH-8){1'b0}}, raw[7:0]};
      3'd5:    return {{(WIDTH-16){1'b0}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  logic [1:0]       off;
  logic [WA-1:0]    word0, word1, cur_word;
  logic             split_op, beat_done, in_beat, in_beat2, op_done, mem_we;
  logic [3:0]       mask4, be_cur;
  logic [7:0]       be8;
  logic [63:0]      wd64, win;
  logic [WIDTH-1:0] wd_cur, rd_word, ld_raw, ld_data;
  logic             accept;

  assign off      = addr_q[1:0];
  assign word0    = addr_q[ADR_WIDTH-1:2];
  assign word1    = word0 + WA'(1);  // wraps modulo depth
  assign split_op = ((mode_q[1:0] == 2'd1) && (off == 2'd3)) ||
                    ((mode_q[1:0] == 2'd2) && (off != 2'd0));
  assign in_beat  = (state_q == BEAT1) || (state_q == BEAT2);
  assign in_beat2 = (state_q == BEAT2);
  assign beat_done = (cnt_q == LAST_CNT);
  assign op_done  = in_beat && beat_done && (in_beat2 || !split_op);
  assign cur_word = in_beat2 ? word1 : word0;
  assign rd_word  = mem[cur_word];

  // Store lanes: place the data and enables in an 8-byte window spanning the
  // addressed word and the next one; beat 1 uses the low half, beat 2 the high.
  assign mask4  = (mode_q[1:0] == 2'd0) ? 4'b0001 :
                  (mode_q[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
  assign be8    = {4'b0000, mask4} << off;
  assign wd64   = {32'b0, wdat_q} << {off, 3'b000};
  assign be_cur = in_beat2 ? be8[7:4] : be8[3:0];
  assign wd_cur = in_beat2 ? wd64[63:32] : wd64[31:0];
  assign mem_we = in_beat && beat_done && store_q;

  // Load assembly: the low word captured in beat 1 sits under the word read
  // now; a single-beat load has nothing above its word.
  assign win     = in_beat2 ? {rd_word, lo_q} : {32'b0, rd_word};
  assign ld_raw  = 32'(win >> {off, 3'b000});
  assign ld_data = extend(ld_raw, mode_q);

  assign accept = bus.valid_in && !bus.stall_in &&
                  ((state_q == IDLE) || (state_q == HOLD));

  // HOLD always exits once stall_in is low, so outside the beats stall_out
  // simply follows stall_in.
  assign bus.stall_out = bus.stall_in || (in_beat && !op_done);
  assign bus.rd_out    = rd_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.we_out    = we_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.fault_out = fault_out_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    mode_d      = mode_q;
    wdat_d      = wdat_q;
    rd_d        = rd_q;
    store_d     = store_q;
    lo_d        = lo_q;
    rd_out_d    = rd_out_q;
    data_out_d  = data_out_q;
    we_out_d    = we_out_q;
    valid_out_d = valid_out_q;
    fault_out_d = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (!((state_q == HOLD) && bus.stall_in)) begin
          state_d     = IDLE;
          rd_out_d    = '0;
          data_out_d  = '0;
          we_out_d    = 1'b0;
          valid_out_d = 1'b0;
          if (accept) begin
            addr_d  = bus.address;
            mode_d  = bus.address_mode;
            wdat_d  = bus.data;
            rd_d    = bus.rd;
            store_d = bus.write;
            if (bus.write || bus.read) begin
              if (legal_mode(bus.address_mode)) begin
                state_d = BEAT1;
                cnt_d   = 2'd0;
              end else begin
                valid_out_d = 1'b1;
                fault_out_d = 1'b1;
              end
            end else if (bus.no_mem) begin
              rd_out_d    = bus.rd;
              data_out_d  = bus.data;
              we_out_d    = 1'b1;
              valid_out_d = 1'b1;
            end
          end
        end
      end
      BEAT1, BEAT2: begin
        cnt_d = cnt_q + 2'd1;
        if (beat_done) begin
          cnt_d = 2'd0;
          if (!in_beat2 && split_op) begin
            state_d = BEAT2;
            lo_d    = rd_word;
          end else begin
            state_d     = HOLD;
            valid_out_d = 1'b1;
            if (!store_q) begin
              rd_out_d   = rd_q;
              data_out_d = ld_data;
              we_out_d   = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      rd_out_q    <= '0;
      data_out_q  <= '0;
      we_out_q    <= 1'b0;
      valid_out_q <= 1'b0;
      fault_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_out_q    <= rd_out_d;
      data_out_q  <= data_out_d;
      we_out_q    <= we_out_d;
      valid_out_q <= valid_out_d;
      fault_out_q <= fault_out_d;
    end
  end

  // Captured operands
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    mode_q  <= mode_d;
    wdat_q  <= wdat_d;
    rd_q    <= rd_d;
    store_q <= store_d;
    lo_q    <= lo_d;
  end

  // RAM write port; a reset edge suppresses any pending beat write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_cur[i]) mem[cur_word][8*i +: 8] <= wd_cur[8*i +: 8];
      end
    end
  end

endmodule
